// File: rtl/serializador_carga_paralela_4bits_pkg.sv
// Shared definitions for the serializer family: FSM state encoding,
// default word width and the parity helper.
// Optional feature macro used by the serializer: SERIALIZADOR_PARIDAD_EN.
package serial_pkg;

  typedef enum logic {
    REPOSO   = 1'b0,
    DESPLAZA = 1'b1
  } estado_t;

  localparam int ANCHO_PALABRA = 4;

  // Even parity over up to 8 bits (unused upper bits are zero-filled).
  function automatic logic paridad_par(input logic [7:0] palabra);
    return ^palabra;
  endfunction

endpackage

// File: rtl/serializador_carga_paralela_4bits_if.sv
// Load/accept handshake plus serial output bundle of the serializer.
// master: upstream/downstream side; slave: the serializer itself.
interface serializador_carga_paralela_4bits_if #(
  parameter int N = 4
);
  logic         carga;
  logic [N-1:0] In;
  logic         listo;
  logic         Sout;
  logic         Sout_valido;
  logic         fin;

  modport master (
    output carga,
    output In,
    input  listo,
    input  Sout,
    input  Sout_valido,
    input  fin
  );

  modport slave (
    input  carga,
    input  In,
    output listo,
    output Sout,
    output Sout_valido,
    output fin
  );
endinterface

// File: rtl/serializador_carga_paralela_4bits_contador_bits.sv
// Down-counter with synchronous load, decrement and a zero flag.
// Load has priority over decrement; reset clears the count.
module contador_bits #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic         decrementa,
  input  logic [W-1:0] valor,
  output logic         cero
);
  logic [W-1:0] cuenta_r;

  // Count register: reset, load, or decrement by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_r <= {W{1'b0}};
    end else if (carga) begin
      cuenta_r <= valor;
    end else if (decrementa) begin
      cuenta_r <= cuenta_r - W'(1'b1);
    end else begin
      cuenta_r <= cuenta_r;
    end
  end

  assign cero = (cuenta_r == {W{1'b0}});

endmodule

// File: rtl/serializador_carga_paralela_4bits.sv
// Parallel-in, serial-out serializer with a load/accept handshake.
// The first bit is registered onto Sout on the accept edge itself, so it is
// visible the cycle after accept; the bit counter then tracks the remaining
// bits and the FSM returns to REPOSO one edge after the last bit, raising fin.
// Optional feature macro: SERIALIZADOR_PARIDAD_EN appends an even-parity bit.
module serializador_carga_paralela_4bits
  import serial_pkg::*;
#(
  parameter int N           = ANCHO_PALABRA,
  parameter bit LSB_PRIMERO = 1'b1
) (
  input  logic clk,
  input  logic reset,
  serializador_carga_paralela_4bits_if.slave bus
);

`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  // Counter holds NB-1 at most.
  localparam int CW = $clog2(NB);

  estado_t       estado_r, estado_s;
  logic [NB-1:0] desp_r, desp_s;
  logic [NB-1:0] palabra_s;
  logic          sout_r, sout_s;
  logic          valido_r, valido_s;
  logic          fin_r, fin_s;
  logic          listo_r, listo_s;
  logic          carga_cnt_s;
  logic          dec_s;
  logic          cnt_cero_s;

  // Bit that goes out next from a shift-register image.
  function automatic logic primer_bit(input logic [NB-1:0] w);
    if (LSB_PRIMERO) begin
      return w[0];
    end else begin
      return w[NB-1];
    end
  endfunction

  // Shift-register image after the outgoing bit has been consumed.
  function automatic logic [NB-1:0] desplazar(input logic [NB-1:0] w);
    if (LSB_PRIMERO) begin
      return w >> 1'b1;
    end else begin
      return w << 1'b1;
    end
  endfunction

  // Word to serialize, with the parity bit placed at the tail of the sequence.
  always_comb begin
    palabra_s = {NB{1'b0}};
`ifdef SERIALIZADOR_PARIDAD_EN
    if (LSB_PRIMERO) begin
      palabra_s = {paridad_par(8'(bus.In)), bus.In};
    end else begin
      palabra_s = {bus.In, paridad_par(8'(bus.In))};
    end
`else
    palabra_s = bus.In;
`endif
  end

  contador_bits #(
    .W(CW)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .carga      (carga_cnt_s),
    .decrementa (dec_s),
    .valor      (CW'(NB - 1)),
    .cero       (cnt_cero_s)
  );

  // Next-state and next-output logic of the two-state FSM.
  always_comb begin
    estado_s    = estado_r;
    desp_s      = desp_r;
    sout_s      = 1'b0;
    valido_s    = 1'b0;
    fin_s       = 1'b0;
    listo_s     = listo_r;
    carga_cnt_s = 1'b0;
    dec_s       = 1'b0;
    case (estado_r)
      REPOSO: begin
        listo_s = 1'b1;
        if (bus.carga && listo_r) begin
          estado_s    = DESPLAZA;
          desp_s      = desplazar(palabra_s);
          sout_s      = primer_bit(palabra_s);
          valido_s    = 1'b1;
          listo_s     = 1'b0;
          carga_cnt_s = 1'b1;
        end else begin
          estado_s = REPOSO;
        end
      end
      DESPLAZA: begin
        if (cnt_cero_s) begin
          // Last bit already presented: close the word.
          estado_s = REPOSO;
          desp_s   = {NB{1'b0}};
          fin_s    = 1'b1;
          listo_s  = 1'b1;
        end else begin
          sout_s   = primer_bit(desp_r);
          desp_s   = desplazar(desp_r);
          valido_s = 1'b1;
          listo_s  = 1'b0;
          dec_s    = 1'b1;
        end
      end
      default: begin
        estado_s = REPOSO;
        desp_s   = {NB{1'b0}};
        listo_s  = 1'b1;
      end
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r <= REPOSO;
      desp_r   <= {NB{1'b0}};
      sout_r   <= 1'b0;
      valido_r <= 1'b0;
      fin_r    <= 1'b0;
      listo_r  <= 1'b1;
    end else begin
      estado_r <= estado_s;
      desp_r   <= desp_s;
      sout_r   <= sout_s;
      valido_r <= valido_s;
      fin_r    <= fin_s;
      listo_r  <= listo_s;
    end
  end

  assign bus.Sout        = sout_r;
  assign bus.Sout_valido = valido_r;
  assign bus.fin         = fin_r;
  assign bus.listo       = listo_r;

endmodule
